scan_mux_bank: RTL
==================

# scan_mux_bank

Parametrised capture-and-scan block: a bank of CHANNELS registers, each WIDTH bits wide, captured in parallel from a flat input bus. A bidirectional, loadable pointer selects one channel at a time and delivers it through a one-entry registered output stage with a valid/ready handshake. It is the next-generation sample-and-select stage between parallel capture logic and a serial consumer, and adds backpressure, pointer load and wrap reporting.

## Interface
Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 8, number of channels (>=2; need not be a power of two)
- PTR_W, derived as $clog2(CHANNELS), pointer width (localparam, not overridable)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cap_en  in  1  capture din into the bank this cycle
- din  in  CHANNELS*WIDTH  channel i occupies din[i*WIDTH +: WIDTH]
- en  in  1  read request: emit the current channel and step the pointer
- incr  in  1  step direction: 1 = up, 0 = down
- ptr_load  in  1  load pointer from ptr_val
- ptr_val  in  PTR_W  pointer load value
- dout  out  WIDTH  output data
- out_ptr  out  PTR_W  channel index carried with dout
- out_valid  out  1  dout/out_ptr valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- wrapped  out  1  one-cycle pulse: pointer wrapped this cycle

## Operation
- Reset (reset low, asynchronous): bank = 0, ptr = 0, dout = 0, out_ptr = 0, out_valid = 0, wrapped = 0.
- Capture: on cap_en, every bank[i] loads its din slice. Otherwise the bank holds.
- Slot free: slot_free = !out_valid | out_ready.
- Read accepted: rd = en & slot_free & !ptr_load.
- On rd:
  - dout <= bank[ptr] (pre-capture value if cap_en is in the same cycle)
  - out_ptr <= ptr
  - out_valid <= 1
  - ptr steps in the incr direction.
- If not rd and out_ready: out_valid <= 0. dout/out_ptr hold their last values.
- If en while slot is not free: ignored. There is no queueing and the pointer does not step.
- Pointer step up: ptr == CHANNELS-1 goes to 0 (wrap). Otherwise ptr+1.
- Pointer step down: ptr == 0 goes to CHANNELS-1 (wrap). Otherwise ptr-1.
- Pointer arithmetic is done in PTR_W bits. Codes >= CHANNELS never appear in ptr.
- Pointer load: ptr_load has priority over en. ptr <= ptr_val. If ptr_val >= CHANNELS, ptr <= CHANNELS-1. No read is issued that cycle.
- wrapped is high for exactly the cycle after a wrapping step, and 0 otherwise.

## Timing
- Read latency: en accepted at edge t; dout/out_valid are valid after edge t.
- Throughput: one channel per cycle while out_ready = 1 and en = 1.
- Handshake: out_valid, dout and out_ptr remain stable while out_valid & !out_ready.
- Simultaneous accept and new read: out_valid stays 1 and dout updates. There is no bubble.
- Capture followed by a read: cap_en at t and en at t+1 returns the new data.
- Reset mid-transfer: out_valid drops immediately (asynchronously) and any pending data is discarded.

## Configuration
- SCAN_WRAP_EN defined: wrap-around behaviour as above, and wrapped pulses.
- SCAN_WRAP_EN undefined:
  - The pointer saturates: up at CHANNELS-1 stays, down at 0 stays.
  - The read is still issued.
  - wrapped is tied to 0.

## Structure
- Shared package scan_mux_pkg:
  - default WIDTH/CHANNELS constants
  - enum for step direction (DIR_DOWN = 0, DIR_UP = 1)
  - ptr_width function equal to $clog2 with a minimum of 1
- Sub-module scan_ptr: pointer register with load, clamp, up/down step, wrap/saturate and wrapped generation.
- Bank, mux and output stage live in the top level.

## Test plan
- Reset, then cap_en with channels 0..7 = 0x10..0x17, then en=1, incr=1, out_ready=1 for 9 cycles -> dout sequence 0x10..0x17 then 0x10, out_ptr 0..7 then 0, wrapped pulses once.
- Same setup, incr=0 from ptr=0 -> dout 0x10, 0x17, 0x16; with SCAN_WRAP_EN undefined -> 0x10, 0x10, 0x10 and wrapped stays 0.
- out_ready=0 for 3 cycles with en=1 -> dout holds 0x10, out_valid=1, ptr stays at 1; release -> next dout is 0x11 with no skipped channel.
- CHANNELS=5, ptr_load with ptr_val=7 -> ptr clamps to 4; en, incr=1 -> dout = bank[4], then bank[0].
- cap_en and en in the same cycle (old ch2=0xAA, new 0x55) -> dout 0xAA; a read of ch2 in a later cycle -> 0x55.
- reset asserted while out_valid=1 and stalled -> out_valid, dout, out_ptr and wrapped all 0 immediately; ptr is 0 after release.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux_bank block.
//   DEFAULT_WIDTH / DEFAULT_CHANNELS : default bank geometry
//   dir_e                            : pointer step direction
//   ptr_width()                      : pointer width for a channel count, never below 1
package scan_mux_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_CHANNELS = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int unsigned ptr_width(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/scan_ptr.sv
// Channel pointer for scan_mux_bank: loadable, clamped, bidirectional stepping.
// With SCAN_WRAP_EN defined the pointer wraps at either end and 'wrapped' pulses for
// the cycle after a wrapping step; otherwise it saturates and 'wrapped' is tied low.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load, load_val load pointer (values beyond the last channel clamp to it)
//   step, dir      advance one channel in the given direction
//   ptr            current pointer
//   wrapped        one-cycle wrap indication
module scan_ptr
  import scan_mux_pkg::*;
#(
  parameter  int unsigned CHANNELS = DEFAULT_CHANNELS,
  localparam int unsigned PTR_W    = ptr_width(CHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  input  logic             step,
  input  dir_e             dir,
  output logic [PTR_W-1:0] ptr,
  output logic             wrapped
);

  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(CHANNELS - 1);

  // Where the pointer goes when stepping past either end.
`ifdef SCAN_WRAP_EN
  localparam logic [PTR_W-1:0] UpFromLast   = '0;
  localparam logic [PTR_W-1:0] DownFromZero = LastIdx;
`else
  localparam logic [PTR_W-1:0] UpFromLast   = LastIdx;
  localparam logic [PTR_W-1:0] DownFromZero = '0;
`endif

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (load_val > LastIdx) ? LastIdx : load_val;
    end else if (step) begin
      unique case (dir)
        DIR_UP:   ptr_d = (ptr_q == LastIdx) ? UpFromLast : ptr_q + 1'b1;
        DIR_DOWN: ptr_d = (ptr_q == '0) ? DownFromZero : ptr_q - 1'b1;
        default:  ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

`ifdef SCAN_WRAP_EN
  logic wrap_d, wrapped_q;

  assign wrap_d = step & ~load & ((dir == DIR_UP) ? (ptr_q == LastIdx) : (ptr_q == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= wrap_d;
    end
  end

  assign wrapped = wrapped_q;
`else
  assign wrapped = 1'b0;
`endif

endmodule

// File: rtl/scan_mux_bank.sv
// Capture-and-scan bank: CHANNELS registers of WIDTH bits captured in parallel from din,
// read out one channel at a time through a one-entry registered valid/ready stage.
// Optional feature macro: SCAN_WRAP_EN (pointer wrap-around and 'wrapped' pulse);
// without it the pointer saturates at either end and 'wrapped' stays 0.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cap_en, din       capture all channels; channel i is din[i*WIDTH +: WIDTH]
//   en, incr          read request and step direction (1 = up)
//   ptr_load, ptr_val pointer load (wins over en, no read that cycle)
//   dout, out_ptr     output data and the channel it came from
//   out_valid         output stage holds data
//   out_ready         consumer accepts when out_valid & out_ready
//   wrapped           pointer wrapped on the previous edge
module scan_mux_bank
  import scan_mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter  int unsigned CHANNELS = DEFAULT_CHANNELS,
  localparam int unsigned PTR_W    = ptr_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap_en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      en,
  input  logic                      incr,
  input  logic                      ptr_load,
  input  logic [PTR_W-1:0]          ptr_val,
  output logic [WIDTH-1:0]          dout,
  output logic [PTR_W-1:0]          out_ptr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      wrapped
);

  logic [WIDTH-1:0] bank_q [CHANNELS];
  logic [PTR_W-1:0] ptr;
  logic             slot_free;
  logic             rd;
  logic [WIDTH-1:0] dout_q;
  logic [PTR_W-1:0] out_ptr_q;
  logic             out_valid_q;

  assign slot_free = ~out_valid_q | out_ready;
  assign rd        = en & slot_free & ~ptr_load;

  // Capture bank; a read in the same cycle sees the pre-capture contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (cap_en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        bank_q[i] <= din[i*WIDTH +: WIDTH];
      end
    end
  end

  scan_ptr #(
    .CHANNELS(CHANNELS)
  ) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .load    (ptr_load),
    .load_val(ptr_val),
    .step    (rd),
    .dir     (dir_e'(incr)),
    .ptr     (ptr),
    .wrapped (wrapped)
  );

  // One-entry output stage; a new read replaces an accepted entry without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q      <= '0;
      out_ptr_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (rd) begin
      dout_q      <= bank_q[ptr];
      out_ptr_q   <= ptr;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign dout      = dout_q;
  assign out_ptr   = out_ptr_q;
  assign out_valid = out_valid_q;

endmodule
